// File: rtl/dda_grid_walker.sv
// DDA grid walker: steps one ray through an N x N tile map, reading one cell per
// step from the map ROM, until it hits a wall, leaves the grid or runs out of steps.
module dda_grid_walker #(
  parameter int N              = 24,
  parameter int DIST_W         = 16,
  parameter int MAX_STEPS      = 64,
  parameter int MAP_DATA_WIDTH = 5,
  localparam int CW = $clog2(N),
  localparam int AW = $clog2(N*N),
  localparam int SW = $clog2(MAX_STEPS+1)
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [CW-1:0]             map_x_in,
  input  logic [CW-1:0]             map_y_in,
  input  logic                      step_x_in,
  input  logic                      step_y_in,
  input  logic [DIST_W-1:0]         side_dist_x_in,
  input  logic [DIST_W-1:0]         side_dist_y_in,
  input  logic [DIST_W-1:0]         delta_dist_x_in,
  input  logic [DIST_W-1:0]         delta_dist_y_in,
  output logic                      ready_out,
  output logic                      map_req_out,
  output logic [AW-1:0]             map_addr_out,
  input  logic                      map_valid_in,
  input  logic [MAP_DATA_WIDTH-1:0] map_data_in,
  output logic                      hit_valid_out,
  output logic                      hit_side_out,
  output logic [MAP_DATA_WIDTH-1:0] hit_wall_out,
  output logic [CW-1:0]             hit_x_out,
  output logic [CW-1:0]             hit_y_out,
  output logic [DIST_W-1:0]         perp_dist_out,
  output logic [SW-1:0]             hit_steps_out,
  output logic                      oob_out,
  output logic                      timeout_out
);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic signed [CW:0] MAX_C = (CW+1)'(N-1);

  state_t state_q, state_d;

  // Ray state; coordinates carry a sign bit so a step off either edge is visible.
  logic signed [CW:0]  x_q, y_q;
  logic                stpx_q, stpy_q;
  logic [DIST_W-1:0]   sdx_q, sdy_q, ddx_q, ddy_q, perp_q;
  logic                side_q, oob_q;
  logic [SW-1:0]       steps_q;
  logic                req_q;
  logic [AW-1:0]       addr_q;

  // Result registers, held until the next ray finishes.
  logic                hv_q, hside_q, hoob_q, hto_q;
  logic [MAP_DATA_WIDTH-1:0] hwall_q;
  logic [CW-1:0]       hx_q, hy_q;
  logic [DIST_W-1:0]   hperp_q;
  logic [SW-1:0]       hsteps_q;

  function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] a,
                                                input logic [DIST_W-1:0] b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? '1 : s[DIST_W-1:0];
  endfunction

  // Candidate step: x wins only on strictly smaller side distance, ties go to y.
  logic               x_lt, n_oob;
  logic signed [CW:0] dx, dy, nx, ny;
  logic [AW-1:0]      n_addr;

  // Next-coordinate, bounds and address computation for the STEP cycle.
  always_comb begin
    x_lt   = sdx_q < sdy_q;
    dx     = stpx_q ? '1 : (CW+1)'(1);
    dy     = stpy_q ? '1 : (CW+1)'(1);
    nx     = x_lt ? x_q + dx : x_q;
    ny     = x_lt ? y_q : y_q + dy;
    n_oob  = nx[CW] || ny[CW] || (nx > MAX_C) || (ny > MAX_C);
    n_addr = AW'(ny[CW-1:0]) * AW'(N) + AW'(nx[CW-1:0]);
  end

  logic fin, fin_map;

  // Next-state logic; fin marks the cycle whose edge enters DONE.
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    fin_map = 1'b0;
    case (state_q)
      S_IDLE: if (start_in) state_d = S_STEP;
      S_STEP: state_d = S_REQ;
      S_REQ: begin
        if (oob_q) begin
          state_d = S_DONE;
          fin     = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (map_valid_in) begin
          if (map_data_in != '0 || steps_q == SW'(MAX_STEPS)) begin
            state_d = S_DONE;
            fin     = 1'b1;
            fin_map = 1'b1;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Ray datapath: latch on start, advance one cell per STEP, issue the map request.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      x_q <= '0; y_q <= '0; stpx_q <= 1'b0; stpy_q <= 1'b0;
      sdx_q <= '0; sdy_q <= '0; ddx_q <= '0; ddy_q <= '0; perp_q <= '0;
      side_q <= 1'b0; oob_q <= 1'b0; steps_q <= '0;
      req_q <= 1'b0; addr_q <= '0;
    end else begin
      req_q <= 1'b0;
      if (state_q == S_IDLE && start_in) begin
        x_q     <= {1'b0, map_x_in};
        y_q     <= {1'b0, map_y_in};
        stpx_q  <= step_x_in;
        stpy_q  <= step_y_in;
        sdx_q   <= side_dist_x_in;
        sdy_q   <= side_dist_y_in;
        ddx_q   <= delta_dist_x_in;
        ddy_q   <= delta_dist_y_in;
        steps_q <= '0;
        oob_q   <= 1'b0;
      end else if (state_q == S_STEP) begin
        steps_q <= steps_q + SW'(1);
        side_q  <= ~x_lt;
        if (x_lt) begin
          perp_q <= sdx_q;
          sdx_q  <= sat_add(sdx_q, ddx_q);
        end else begin
          perp_q <= sdy_q;
          sdy_q  <= sat_add(sdy_q, ddy_q);
        end
        // Off-grid: keep the last in-range cell so it can be reported.
        oob_q <= n_oob;
        if (!n_oob) begin
          x_q    <= nx;
          y_q    <= ny;
          req_q  <= 1'b1;
          addr_q <= n_addr;
        end
      end
    end
  end

  // Result capture on entry to DONE; hit_valid is the one-cycle DONE strobe.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hv_q <= 1'b0; hside_q <= 1'b0; hoob_q <= 1'b0; hto_q <= 1'b0;
      hwall_q <= '0; hx_q <= '0; hy_q <= '0; hperp_q <= '0; hsteps_q <= '0;
    end else begin
      hv_q <= fin;
      if (fin) begin
        hside_q  <= side_q;
        hx_q     <= x_q[CW-1:0];
        hy_q     <= y_q[CW-1:0];
        hperp_q  <= perp_q;
        hsteps_q <= steps_q;
        hoob_q   <= ~fin_map;
        hwall_q  <= fin_map ? map_data_in : '0;
        hto_q    <= fin_map && (map_data_in == '0);
      end
    end
  end

  assign ready_out     = (state_q == S_IDLE);
  assign map_req_out   = req_q;
  assign map_addr_out  = addr_q;
  assign hit_valid_out = hv_q;
  assign hit_side_out  = hside_q;
  assign hit_wall_out  = hwall_q;
  assign hit_x_out     = hx_q;
  assign hit_y_out     = hy_q;
  assign perp_dist_out = hperp_q;
  assign hit_steps_out = hsteps_q;
  assign oob_out       = hoob_q;
  assign timeout_out   = hto_q;

endmodule

// File: tb/tb_dda_grid_walker.sv
// Scoreboard bench for dda_grid_walker: stimulus pushes expected requests and
// results with their cycle numbers; a negedge monitor pops and compares them.
module tb_dda_grid_walker;

  localparam int N = 24, DW = 16, MS = 4, MDW = 5;
  localparam int CW = $clog2(N), AW = $clog2(N*N), SW = $clog2(MS+1);

  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stx = 1'b0, sty = 1'b0;
  logic [CW-1:0] mx = '0, my = '0;
  logic [DW-1:0] sdx = '0, sdy = '0, ddx = '0, ddy = '0;
  logic ready, req, mvalid, hv, hside, oob, tmo;
  logic [AW-1:0] addr;
  logic [MDW-1:0] mdata, hwall;
  logic [CW-1:0] hx, hy;
  logic [DW-1:0] perp;
  logic [SW-1:0] hsteps;

  dda_grid_walker #(.N(N), .DIST_W(DW), .MAX_STEPS(MS), .MAP_DATA_WIDTH(MDW)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .start_in(start),
    .map_x_in(mx), .map_y_in(my), .step_x_in(stx), .step_y_in(sty),
    .side_dist_x_in(sdx), .side_dist_y_in(sdy),
    .delta_dist_x_in(ddx), .delta_dist_y_in(ddy),
    .ready_out(ready), .map_req_out(req), .map_addr_out(addr),
    .map_valid_in(mvalid), .map_data_in(mdata),
    .hit_valid_out(hv), .hit_side_out(hside), .hit_wall_out(hwall),
    .hit_x_out(hx), .hit_y_out(hy), .perp_dist_out(perp),
    .hit_steps_out(hsteps), .oob_out(oob), .timeout_out(tmo));

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Map ROM model: data returns two cycles after the request.
  logic [MDW-1:0] mem [0:1023];
  logic v1 = 1'b0, v2 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [MDW-1:0] d2 = '0;
  always @(posedge clk) begin
    v1 <= req; a1 <= addr;
    v2 <= v1;  d2 <= mem[a1];
  end
  assign mvalid = v2;
  assign mdata  = d2;

  typedef struct {
    int cyc; int side; int wall; int x; int y; int perp; int steps; int oob; int to;
  } hit_t;
  typedef struct { int cyc; int addr; } req_t;

  hit_t hq[$];
  req_t rq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  // Monitor: every request and every result strobe must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (req) begin
        if (rq.size() == 0) chk("unexpected_req", 32'(addr), 32'hFFFF_FFFF);
        else begin
          req_t r;
          r = rq.pop_front();
          chk("req_cyc", cnt, r.cyc);
          chk("req_addr", 32'(addr), r.addr);
        end
      end
      if (hv) begin
        if (hq.size() == 0) chk("unexpected_hit", 32'(hv), 32'd0);
        else begin
          hit_t h;
          h = hq.pop_front();
          chk("hit_cyc", cnt, h.cyc);
          chk("hit_side", 32'(hside), h.side);
          chk("hit_wall", 32'(hwall), h.wall);
          chk("hit_x", 32'(hx), h.x);
          chk("hit_y", 32'(hy), h.y);
          chk("perp", 32'(perp), h.perp);
          chk("steps", 32'(hsteps), h.steps);
          chk("oob", 32'(oob), h.oob);
          chk("timeout", 32'(tmo), h.to);
        end
      end
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic fire(input int x, input int y, input bit sx, input bit sy,
                      input int sdx_v, input int sdy_v, input int ddx_v, input int ddy_v,
                      output int s);
    @(posedge clk); #1;
    mx = CW'(x); my = CW'(y); stx = sx; sty = sy;
    sdx = DW'(sdx_v); sdy = DW'(sdy_v); ddx = DW'(ddx_v); ddy = DW'(ddy_v);
    start = 1'b1;
    s = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic exp_req(input int cyc, input int a);
    req_t r;
    r.cyc = cyc; r.addr = a;
    rq.push_back(r);
  endtask

  task automatic exp_hit(input int cyc, input int side, input int wall, input int x,
                         input int y, input int p, input int st, input int ob, input int to);
    hit_t h;
    h.cyc = cyc; h.side = side; h.wall = wall; h.x = x; h.y = y;
    h.perp = p; h.steps = st; h.oob = ob; h.to = to;
    hq.push_back(h);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ready && hq.size() == 0 && rq.size() == 0) break;
    end
    chk({nm, "_drain"}, 32'(hq.size() + rq.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_req"}, 32'(req), 32'd0);
    chk({nm, "_addr"}, 32'(addr), 32'd0);
    chk({nm, "_hv"}, 32'(hv), 32'd0);
    chk({nm, "_results"}, {hside, hwall, hx, hy, oob, tmo}, 32'd0);
    chk({nm, "_perp"}, 32'(perp), 32'd0);
    chk({nm, "_steps"}, 32'(hsteps), 32'd0);
  endtask

  initial begin
    int s;
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Single x-step hit.
    mem[51] = 5'd7;
    fire(2, 2, 0, 0, 'h0080, 'h0100, 'h0100, 'h0100, s);
    exp_req(s+2, 51);
    exp_hit(s+5, 0, 7, 3, 2, 'h0080, 1, 0, 0);
    wait_idle("t1");

    // Three x-steps, requests spaced four cycles.
    clear_map(); mem[53] = 5'd4;
    fire(2, 2, 0, 0, 'h0080, 'h0400, 'h0100, 'h0100, s);
    exp_req(s+2, 51); exp_req(s+6, 52); exp_req(s+10, 53);
    exp_hit(s+13, 0, 4, 5, 2, 'h0280, 3, 0, 0);
    wait_idle("t2");

    // Tie goes to y.
    clear_map(); mem[274] = 5'd2;
    fire(10, 10, 0, 0, 'h0100, 'h0100, 'h0100, 'h0100, s);
    exp_req(s+2, 274);
    exp_hit(s+5, 1, 2, 10, 11, 'h0100, 1, 0, 0);
    wait_idle("t3");

    // Out of bounds off the left, right and top edges: no request.
    fire(0, 5, 1, 0, 'h0010, 'h0F00, 'h0100, 'h0100, s);
    exp_hit(s+3, 0, 0, 0, 5, 'h0010, 1, 1, 0);
    wait_idle("oob_left");
    fire(23, 7, 0, 0, 'h0010, 'h0F00, 'h0100, 'h0100, s);
    exp_hit(s+3, 0, 0, 23, 7, 'h0010, 1, 1, 0);
    wait_idle("oob_right");
    fire(4, 0, 0, 1, 'h0F00, 'h0010, 'h0100, 'h0100, s);
    exp_hit(s+3, 1, 0, 4, 0, 'h0010, 1, 1, 0);
    wait_idle("oob_top");

    // Saturating side distance: x stays at 0xFFFF so the second step is y.
    clear_map(); mem[150] = 5'd3;
    fire(5, 5, 0, 0, 'hFF80, 'hFFF0, 'h0100, 'h0100, s);
    exp_req(s+2, 126); exp_req(s+6, 150);
    exp_hit(s+9, 1, 3, 6, 6, 'hFFF0, 2, 0, 0);
    wait_idle("sat");

    // Timeout after MAX_STEPS empty reads; a mid-ray start is ignored.
    clear_map();
    fire(10, 10, 0, 0, 'h0010, 'h0F00, 'h0100, 'h0100, s);
    exp_req(s+2, 251); exp_req(s+6, 252); exp_req(s+10, 253); exp_req(s+14, 254);
    exp_hit(s+17, 0, 0, 14, 10, 'h0310, 4, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    mx = 5'd1; my = 5'd1; sdx = 'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("timeout");

    // Reset during WAIT: ray aborted, late map data ignored.
    clear_map(); mem[51] = 5'd7;
    fire(2, 2, 0, 0, 'h0080, 'h0100, 'h0100, 'h0100, s);
    exp_req(s+2, 51);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("midreset");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_rq", 32'(rq.size()), 32'd0);

    // Fresh ray after reset completes normally.
    fire(2, 2, 0, 0, 'h0080, 'h0100, 'h0100, 'h0100, s);
    exp_req(s+2, 51);
    exp_hit(s+5, 0, 7, 3, 2, 'h0080, 1, 0, 0);
    wait_idle("post_reset");

    repeat (5) @(posedge clk);
    #1;
    chk("final_queues", 32'(hq.size() + rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
